// File: rtl/riscv_regfile_pkg.sv
// Shared constants, the even-parity helper and the write-port request type
// for the multi-port integer register file.
package riscv_regfile_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned NREGS_DEF  = 32;
  localparam int unsigned AW_DEF     = $clog2(NREGS_DEF);
  localparam int unsigned NUM_RD_DEF = 4;
  localparam int unsigned NUM_WR_DEF = 2;

  // Widest register the parity helper covers; narrower data is zero-extended,
  // which leaves the parity unchanged.
  localparam int unsigned PAR_MAX_W  = 64;

  // One write-port request at the default configuration.
  typedef struct packed {
    logic                en;
    logic [AW_DEF-1:0]   addr;
    logic [XLEN_DEF-1:0] data;
  } wr_req_t;

  // Even-parity bit: chosen so data plus parity holds an even number of ones.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
    logic p;
    p = 1'b0;
    for (int unsigned i = 0; i < PAR_MAX_W; i++) begin
      p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/riscv_regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, set on
// reserve at issue, cleared on writeback or flush, with a per-read-port lookup.
// Register 0 is never busy.
module riscv_regfile_scoreboard #(
  parameter  int unsigned NREGS  = 32,
  parameter  int unsigned NUM_RD = 4,
  parameter  int unsigned NUM_WR = 2,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  input  logic                 flush,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  input  logic [NUM_RD-1:0]    rd_fwd,
  output logic [NREGS-1:0]     busy,
  output logic [NUM_RD-1:0]    rd_busy
);

  logic [NREGS-1:0] busy_nxt;

  // Next busy state: flush, then reserve (a new producer wins over a
  // simultaneous writeback), then writeback clear, else hold.
  always_comb begin
    busy_nxt = busy;
    for (int unsigned r = 1; r < NREGS; r++) begin
      if (flush) begin
        busy_nxt[r] = 1'b0;
      end else if (rsv_en && (rsv_addr == AW'(r))) begin
        busy_nxt[r] = 1'b1;
      end else begin
        for (int unsigned w = 0; w < NUM_WR; w++) begin
          if (wr_en[w] && (wr_addr[w*AW +: AW] == AW'(r))) begin
            busy_nxt[r] = 1'b0;
          end
        end
      end
    end
    busy_nxt[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Per-port lookup; a register being forwarded this cycle is already satisfied.
  always_comb begin
    rd_busy = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      rd_busy[p] = busy[rd_addr[p*AW +: AW]] && !rd_fwd[p];
    end
  end

endmodule

// File: rtl/riscv_regfile_mp.sv
// Multi-port integer register file with pending-write scoreboard.
// NUM_RD combinational read ports, NUM_WR synchronous write ports, optional
// same-cycle write-to-read bypass (BYPASS). x0 is hardwired to zero.
// Optional macro RISCV_REGFILE_PARITY_EN adds a stored even-parity bit per
// register and a per-read-port parity error flag (XLEN must not exceed 64).
module riscv_regfile_mp
  import riscv_regfile_pkg::*;
#(
  parameter  int unsigned XLEN   = XLEN_DEF,
  parameter  int unsigned NREGS  = NREGS_DEF,
  parameter  int unsigned NUM_RD = NUM_RD_DEF,
  parameter  int unsigned NUM_WR = NUM_WR_DEF,
  parameter  int unsigned BYPASS = 1,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_RD*AW-1:0]   rd_addr_i,
  output logic [NUM_RD*XLEN-1:0] rd_data_o,
  output logic [NUM_RD-1:0]      rd_busy_o,
  input  logic [NUM_WR-1:0]      wr_en_i,
  input  logic [NUM_WR*AW-1:0]   wr_addr_i,
  input  logic [NUM_WR*XLEN-1:0] wr_data_i,
  input  logic                   rsv_en_i,
  input  logic [AW-1:0]          rsv_addr_i,
  input  logic                   flush_i,
  output logic [NREGS-1:0]       busy_o,
  output logic                   wr_conflict_o,
  output logic [NUM_RD-1:0]      par_err_o
);

  logic [XLEN-1:0]   mem [NREGS];
  logic [NUM_WR-1:0] wr_act;
  logic [NUM_RD-1:0] rd_fwd;

  // Writes are qualified by reset so nothing is forwarded or flagged while
  // the file is held in reset.
  assign wr_act = wr_en_i & {NUM_WR{reset_n}};

  // Register storage; ports applied in ascending order so the highest index wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        mem[r] <= '0;
      end
    end else begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wr_act[w] && (wr_addr_i[w*AW +: AW] != '0)) begin
          mem[wr_addr_i[w*AW +: AW]] <= wr_data_i[w*XLEN +: XLEN];
        end
      end
    end
  end

  // Read ports: stored value, overridden by the highest-index matching write when bypassing.
  always_comb begin
    rd_data_o = '0;
    rd_fwd    = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      if (rd_addr_i[p*AW +: AW] != '0) begin
        rd_data_o[p*XLEN +: XLEN] = mem[rd_addr_i[p*AW +: AW]];
        if (BYPASS != 0) begin
          for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_act[w] && (wr_addr_i[w*AW +: AW] == rd_addr_i[p*AW +: AW])) begin
              rd_data_o[p*XLEN +: XLEN] = wr_data_i[w*XLEN +: XLEN];
              rd_fwd[p]                 = 1'b1;
            end
          end
        end
      end
    end
  end

  // Flag any pair of enabled write ports aimed at the same nonzero register.
  always_comb begin
    wr_conflict_o = 1'b0;
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      for (int unsigned j = i + 1; j < NUM_WR; j++) begin
        if (wr_act[i] && wr_act[j] &&
            (wr_addr_i[i*AW +: AW] == wr_addr_i[j*AW +: AW]) &&
            (wr_addr_i[i*AW +: AW] != '0)) begin
          wr_conflict_o = 1'b1;
        end
      end
    end
  end

  riscv_regfile_scoreboard #(
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clock    (clock),
    .reset_n  (reset_n),
    .rsv_en   (rsv_en_i),
    .rsv_addr (rsv_addr_i),
    .flush    (flush_i),
    .wr_en    (wr_act),
    .wr_addr  (wr_addr_i),
    .rd_addr  (rd_addr_i),
    .rd_fwd   (rd_fwd),
    .busy     (busy_o),
    .rd_busy  (rd_busy_o)
  );

`ifdef RISCV_REGFILE_PARITY_EN
  logic [NREGS-1:0] par_mem;

  // Parity storage tracks the data written alongside it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      par_mem <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wr_act[w] && (wr_addr_i[w*AW +: AW] != '0)) begin
          par_mem[wr_addr_i[w*AW +: AW]] <= even_parity(PAR_MAX_W'(wr_data_i[w*XLEN +: XLEN]));
        end
      end
    end
  end

  // Recompute parity of stored data; forwarded data and x0 never flag.
  always_comb begin
    par_err_o = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      if ((rd_addr_i[p*AW +: AW] != '0) && !rd_fwd[p]) begin
        par_err_o[p] = even_parity(PAR_MAX_W'(mem[rd_addr_i[p*AW +: AW]])) !=
                       par_mem[rd_addr_i[p*AW +: AW]];
      end
    end
  end
`else
  assign par_err_o = '0;
`endif

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Bench for riscv_regfile_mp: a bypassing and a non-bypassing instance share
// stimulus; both are compared against an array-based reference model.
module tb_riscv_regfile_mp;
  import riscv_regfile_pkg::*;

  logic         clock;
  logic         reset_n;
  logic [19:0]  rd_addr;
  logic [127:0] rd_data1, rd_data0;
  logic [3:0]   rd_busy1, rd_busy0;
  logic [1:0]   wr_en;
  logic [9:0]   wr_addr;
  logic [63:0]  wr_data;
  logic         rsv_en;
  logic [4:0]   rsv_addr;
  logic         flush;
  logic [31:0]  busy1, busy0;
  logic         conf1, conf0;
  logic [3:0]   par1, par0;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [32];
  logic [31:0] m_busy;

  riscv_regfile_mp #(.BYPASS(1)) dut (
    .clock(clock), .reset_n(reset_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data1),
    .rd_busy_o(rd_busy1), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .flush_i(flush), .busy_o(busy1),
    .wr_conflict_o(conf1), .par_err_o(par1)
  );

  riscv_regfile_mp #(.BYPASS(0)) dut_nb (
    .clock(clock), .reset_n(reset_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data0),
    .rd_busy_o(rd_busy0), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .flush_i(flush), .busy_o(busy0),
    .wr_conflict_o(conf0), .par_err_o(par0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic wr_req_t req(input int w);
    wr_req_t r;
    r.en   = wr_en[w];
    r.addr = wr_addr[w*5 +: 5];
    r.data = wr_data[w*32 +: 32];
    return r;
  endfunction

  function automatic bit written(input logic [4:0] a);
    bit hit = 0;
    for (int w = 0; w < 2; w++) begin
      wr_req_t r = req(w);
      if (reset_n && r.en && r.addr == a && a != 0) hit = 1;
    end
    return hit;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
    logic [31:0] v;
    if (!reset_n || a == 0) return 32'h0;
    v = m_mem[a];
    if (byp) begin
      for (int w = 0; w < 2; w++) begin
        wr_req_t r = req(w);
        if (r.en && r.addr == a) v = r.data;
      end
    end
    return v;
  endfunction

  function automatic logic exp_rbusy(input logic [4:0] a, input bit byp);
    if (!reset_n || a == 0) return 1'b0;
    return m_busy[a] && !(byp && written(a));
  endfunction

  function automatic logic exp_conflict();
    wr_req_t r0 = req(0);
    wr_req_t r1 = req(1);
    return reset_n && r0.en && r1.en && (r0.addr == r1.addr) && (r0.addr != 0);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_mem[r] = 32'h0;
    m_busy = 32'h0;
  endtask

  task automatic model_update();
    logic [31:0] nb;
    if (!reset_n) begin
      model_reset();
    end else begin
      nb = m_busy;
      for (int r = 1; r < 32; r++) begin
        if (flush) nb[r] = 1'b0;
        else if (rsv_en && rsv_addr == 5'(r)) nb[r] = 1'b1;
        else if (written(5'(r))) nb[r] = 1'b0;
      end
      for (int w = 0; w < 2; w++) begin
        wr_req_t r = req(w);
        if (r.en && r.addr != 0) m_mem[r.addr] = r.data;
      end
      m_busy = nb;
    end
  endtask

  task automatic check_outputs();
    for (int p = 0; p < 4; p++) begin
      logic [4:0] a = rd_addr[p*5 +: 5];
      chk($sformatf("rd%0d_data_byp a=%0d", p, a), 64'(rd_data1[p*32 +: 32]), 64'(exp_read(a, 1)));
      chk($sformatf("rd%0d_data_nobyp a=%0d", p, a), 64'(rd_data0[p*32 +: 32]), 64'(exp_read(a, 0)));
      chk($sformatf("rd%0d_busy_byp a=%0d", p, a), 64'(rd_busy1[p]), 64'(exp_rbusy(a, 1)));
      chk($sformatf("rd%0d_busy_nobyp a=%0d", p, a), 64'(rd_busy0[p]), 64'(exp_rbusy(a, 0)));
      chk($sformatf("rd%0d_par_err", p), 64'({par1[p], par0[p]}), 64'(0));
    end
    chk("wr_conflict_byp", 64'(conf1), 64'(exp_conflict()));
    chk("wr_conflict_nobyp", 64'(conf0), 64'(exp_conflict()));
    chk("busy_vec_byp", 64'(busy1), 64'(reset_n ? m_busy : 32'h0));
    chk("busy_vec_nobyp", 64'(busy0), 64'(reset_n ? m_busy : 32'h0));
  endtask

  task automatic step();
    #1;
    check_outputs();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle();
    wr_en = '0; rsv_en = 1'b0; flush = 1'b0;
  endtask

  function automatic logic [19:0] all_ports(input logic [4:0] a);
    return {a, a, a, a};
  endfunction

  initial begin
    reset_n = 1'b0;
    idle();
    rd_addr = all_ports(5'd5); wr_addr = '0; wr_data = '0; rsv_addr = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_outputs();
    chk("reset_rd_data", 64'(rd_data1), 64'(0));
    chk("reset_busy", 64'(busy1), 64'(0));
    reset_n = 1'b1;

    // write to x0 is discarded
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'hDEADBEEF};
    rd_addr = all_ports(5'd0);
    step();
    idle();
    step();
    chk("x0_reads_zero", 64'(rd_data1[31:0]), 64'(0));

    // same-address dual write: highest port wins, conflict flagged
    wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'h22222222, 32'h11111111};
    rd_addr = all_ports(5'd1);
    #1 chk("conflict_x3", 64'(conf1), 64'(1));
    step();
    idle(); rd_addr = all_ports(5'd3);
    step();
    chk("x3_port1_wins", 64'(rd_data1[95:64]), 64'h22222222);

    // bypass with busy destination
    rsv_en = 1'b1; rsv_addr = 5'd7; rd_addr = all_ports(5'd7);
    step();
    idle(); wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'hA5A5A5A5};
    #1 chk("bypass_x7_data", 64'(rd_data1[31:0]), 64'hA5A5A5A5);
    chk("bypass_x7_busy", 64'(rd_busy1[0]), 64'(0));
    chk("nobyp_x7_busy", 64'(rd_busy0[0]), 64'(1));
    step();
    idle();
    step();
    chk("nobyp_x7_next", 64'(rd_data0[31:0]), 64'hA5A5A5A5);

    // reserve x9, writeback, then reserve+writeback together
    rsv_en = 1'b1; rsv_addr = 5'd9; rd_addr = all_ports(5'd9);
    step();
    idle();
    step();
    chk("x9_busy_pending", 64'(rd_busy1[2]), 64'(1));
    wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h99, 32'h0};
    step();
    idle(); rsv_en = 1'b1; rsv_addr = 5'd9; wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = 64'h1234;
    step();
    idle();
    step();
    chk("x9_rsv_beats_wb", 64'(busy1[9]), 64'(1));

    // flush
    rsv_en = 1'b1; rsv_addr = 5'd4; step();
    rsv_addr = 5'd5; step();
    idle(); flush = 1'b1; step();
    idle(); step();
    chk("flush_clears", 64'(busy1), 64'(0));
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd6; step();
    idle(); step();
    chk("flush_beats_rsv", 64'(busy1[6]), 64'(0));

    // asynchronous reset mid-cycle with writes pending
    rsv_en = 1'b1; rsv_addr = 5'd11; step();
    idle(); wr_en = 2'b11; wr_addr = {5'd10, 5'd11}; wr_data = {32'hCAFE0000, 32'h0000BEEF};
    rd_addr = {5'd10, 5'd11, 5'd3, 5'd7};
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_outputs();
    @(posedge clock);
    model_update();
    #1 reset_n = 1'b1;
    idle();
    step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 4; p++)
        rd_addr[p*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wr_en = 2'($urandom);
      for (int w = 0; w < 2; w++) wr_addr[w*5 +: 5] = 5'($urandom_range(0, 7));
      wr_data = {$urandom, $urandom};
      rsv_en = 1'($urandom);
      rsv_addr = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
